// File: rtl/uart_ctrl.sv
// UART controller: shared baud tick, TX FIFO feeding a framed serial transmitter,
// and a 2-flop-synchronised receiver with parity/frame checking and break handling.
module uart_ctrl #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int OSR        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       baud_div,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              tx_busy,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_parity_err,
  output logic              rx_frame_err,
  output logic [2:0]        tx_state_dbg,
  output logic [2:0]        rx_state_dbg
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(OSR);
  localparam int BW = $clog2(DATA_W);
  localparam logic [OW-1:0] T_LAST   = OW'(OSR - 1);
  localparam logic [OW-1:0] T_HALF   = OW'(OSR / 2 - 1);
  localparam logic [OW-1:0] T_ONE    = OW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_e;

  // Baud tick: the divisor is sampled only at wrap so a change never truncates a period.
  logic [15:0] baud_cnt_q, baud_cnt_d, div_q, div_d;
  logic        tick;

  always_comb begin
    tick       = (baud_cnt_q == div_q);
    baud_cnt_d = baud_cnt_q + 16'd1;
    div_d      = div_q;
    if (tick) begin
      baud_cnt_d = '0;
      div_d      = baud_div;
    end
  end

  // TX FIFO. Write handshake: a word is taken on a clk edge where tx_valid and
  // tx_ready are both 1; tx_valid while full is ignored. Pointers carry a wrap bit.
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              fifo_empty, fifo_full, push, pop;
  logic [DATA_W-1:0] fifo_rdata;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_rdata = mem_q[rd_ptr_q[AW-1:0]];
  assign push       = tx_valid && !fifo_full;
  assign tx_ready   = !fifo_full;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= tx_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_cnt_q <= '0;
      div_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      baud_cnt_q <= baud_cnt_d;
      div_q      <= div_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // TX FSM
  tx_state_e         tx_state_q, tx_state_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [OW-1:0]     tx_tcnt_q, tx_tcnt_d;
  logic [BW-1:0]     tx_bit_q, tx_bit_d;
  logic              tx_q, tx_d, tx_par_q, tx_par_d, tx_pen_q, tx_pen_d;
  logic              tx_stop2_q, tx_stop2_d, tx_second_q, tx_second_d;
  logic              tx_bit_end, tx_load;

  assign tx_bit_end = tick && (tx_tcnt_q == T_LAST);
  // A new frame starts from IDLE or straight out of the final stop bit.
  assign tx_load = !fifo_empty && ((tx_state_q == TX_IDLE) ||
                   ((tx_state_q == TX_STOP) && tx_bit_end && (!tx_stop2_q || tx_second_q)));
  assign pop     = tx_load;

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_shift_d  = tx_shift_q;
    tx_tcnt_d   = tx_tcnt_q;
    tx_bit_d    = tx_bit_q;
    tx_d        = tx_q;
    tx_par_d    = tx_par_q;
    tx_pen_d    = tx_pen_q;
    tx_stop2_d  = tx_stop2_q;
    tx_second_d = tx_second_q;
    if ((tx_state_q != TX_IDLE) && tick) tx_tcnt_d = tx_bit_end ? '0 : tx_tcnt_q + T_ONE;
    case (tx_state_q)
      TX_START: if (tx_bit_end) begin
        tx_state_d = TX_DATA;
        tx_bit_d   = '0;
        tx_d       = tx_shift_q[0];
      end
      TX_DATA: if (tx_bit_end) begin
        if (tx_bit_q == BIT_LAST) begin
          tx_state_d  = tx_pen_q ? TX_PARITY : TX_STOP;
          tx_d        = tx_pen_q ? tx_par_q : 1'b1;
          tx_second_d = 1'b0;
        end else begin
          tx_bit_d   = tx_bit_q + BIT_ONE;
          tx_shift_d = tx_shift_q >> 1;
          tx_d       = tx_shift_q[1];
        end
      end
      TX_PARITY: if (tx_bit_end) begin
        tx_state_d  = TX_STOP;
        tx_d        = 1'b1;
        tx_second_d = 1'b0;
      end
      TX_STOP: if (tx_bit_end) begin
        if (tx_stop2_q && !tx_second_q) begin
          tx_second_d = 1'b1;
        end else begin
          tx_state_d = TX_IDLE;
          tx_d       = 1'b1;
        end
      end
      default: tx_d = 1'b1;
    endcase
    if (tx_load) begin
      tx_state_d = TX_START;
      tx_d       = 1'b0;
      tx_tcnt_d  = '0;
      tx_shift_d = fifo_rdata;
      tx_pen_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
      tx_par_d   = (^fifo_rdata) ^ (parity_mode == 2'b10);
      tx_stop2_d = stop2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q  <= TX_IDLE;
      tx_shift_q  <= '0;
      tx_tcnt_q   <= '0;
      tx_bit_q    <= '0;
      tx_q        <= 1'b1;
      tx_par_q    <= 1'b0;
      tx_pen_q    <= 1'b0;
      tx_stop2_q  <= 1'b0;
      tx_second_q <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_shift_q  <= tx_shift_d;
      tx_tcnt_q   <= tx_tcnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_q        <= tx_d;
      tx_par_q    <= tx_par_d;
      tx_pen_q    <= tx_pen_d;
      tx_stop2_q  <= tx_stop2_d;
      tx_second_q <= tx_second_d;
    end
  end

  assign tx           = tx_q;
  assign tx_busy      = !fifo_empty || (tx_state_q != TX_IDLE);
  assign tx_state_dbg = tx_state_q;

  // RX FSM; rx_s_q is the only form of rx the logic ever looks at.
  rx_state_e         rx_state_q, rx_state_d;
  logic              rx_meta_q, rx_s_q;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic [OW-1:0]     rx_tcnt_q, rx_tcnt_d;
  logic [BW-1:0]     rx_bit_q, rx_bit_d;
  logic              rx_pen_q, rx_pen_d, rx_odd_q, rx_odd_d, rx_perr_q, rx_perr_d;
  logic              rx_valid_q, rx_valid_d, rx_perr_out_q, rx_perr_out_d, rx_ferr_q, rx_ferr_d;
  logic              rx_half, rx_sample, rx_timing;

  assign rx_timing = (rx_state_q != RX_IDLE) && (rx_state_q != RX_WAIT_HIGH);
  assign rx_half   = tick && (rx_state_q == RX_START) && (rx_tcnt_q == T_HALF);
  assign rx_sample = tick && rx_timing && (rx_state_q != RX_START) && (rx_tcnt_q == T_LAST);

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_shift_d    = rx_shift_q;
    rx_tcnt_d     = rx_tcnt_q;
    rx_bit_d      = rx_bit_q;
    rx_pen_d      = rx_pen_q;
    rx_odd_d      = rx_odd_q;
    rx_perr_d     = rx_perr_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    rx_perr_out_d = rx_perr_out_q;
    rx_ferr_d     = rx_ferr_q;
    if (rx_timing && tick) rx_tcnt_d = (rx_half || rx_sample) ? '0 : rx_tcnt_q + T_ONE;
    case (rx_state_q)
      RX_IDLE: begin
        rx_tcnt_d = '0;
        if (!rx_s_q) begin
          rx_state_d = RX_START;
          rx_pen_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
          rx_odd_d   = (parity_mode == 2'b10);
          rx_perr_d  = 1'b0;
        end
      end
      RX_START: if (rx_half) begin
        rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
        rx_bit_d   = '0;
      end
      RX_DATA: if (rx_sample) begin
        rx_shift_d = {rx_s_q, rx_shift_q[DATA_W-1:1]};
        rx_bit_d   = rx_bit_q + BIT_ONE;
        if (rx_bit_q == BIT_LAST) rx_state_d = rx_pen_q ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: if (rx_sample) begin
        rx_perr_d  = (^rx_shift_q) ^ rx_odd_q ^ rx_s_q;
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_sample) begin
        rx_data_d     = rx_shift_q;
        rx_perr_out_d = rx_perr_q;
        rx_ferr_d     = !rx_s_q;
        rx_valid_d    = 1'b1;
        rx_state_d    = rx_s_q ? RX_IDLE : RX_WAIT_HIGH;
      end
      RX_WAIT_HIGH: if (rx_s_q) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      rx_state_q    <= RX_IDLE;
      rx_shift_q    <= '0;
      rx_tcnt_q     <= '0;
      rx_bit_q      <= '0;
      rx_pen_q      <= 1'b0;
      rx_odd_q      <= 1'b0;
      rx_perr_q     <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_perr_out_q <= 1'b0;
      rx_ferr_q     <= 1'b0;
    end else begin
      rx_meta_q     <= rx;
      rx_s_q        <= rx_meta_q;
      rx_state_q    <= rx_state_d;
      rx_shift_q    <= rx_shift_d;
      rx_tcnt_q     <= rx_tcnt_d;
      rx_bit_q      <= rx_bit_d;
      rx_pen_q      <= rx_pen_d;
      rx_odd_q      <= rx_odd_d;
      rx_perr_q     <= rx_perr_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_perr_out_q <= rx_perr_out_d;
      rx_ferr_q     <= rx_ferr_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_out_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_state_dbg  = rx_state_q;
endmodule

// File: tb/tb_uart_ctrl.sv
// Directed + randomized bench for uart_ctrl: frames on tx and rx strobes are
// compared against a bit-list model of a UART frame built in the bench.
module tb_uart_ctrl;
  localparam int DATA_W = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int OSR = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [15:0]       baud_div = '0;
  logic [1:0]        parity_mode = 2'b00;
  logic              stop2 = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_valid = 1'b0;
  logic              tx_ready, tx, tx_busy, rx;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid, rx_parity_err, rx_frame_err;
  logic [2:0]        tx_state_dbg, rx_state_dbg;
  logic              rx_drv = 1'b1;
  logic              loop_en = 1'b0;
  logic              mon_en = 1'b1;

  int errors = 0;
  int checks = 0;

  assign rx = loop_en ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_ctrl #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .OSR(OSR)) dut (
    .clk(clk), .reset(reset), .baud_div(baud_div), .parity_mode(parity_mode),
    .stop2(stop2), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx(tx), .tx_busy(tx_busy), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
    .tx_state_dbg(tx_state_dbg), .rx_state_dbg(rx_state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: a frame is a list of line levels, one per bit period.
  function automatic bit has_parity(input logic [1:0] pm);
    return (pm == 2'b01) || (pm == 2'b10);
  endfunction

  function automatic int frame_len(input logic [1:0] pm, input logic s2);
    return 1 + DATA_W + (has_parity(pm) ? 1 : 0) + 1 + (s2 ? 1 : 0);
  endfunction

  function automatic logic [15:0] frame_bits(input logic [DATA_W-1:0] d, input logic [1:0] pm,
                                             input logic s2);
    logic [15:0] b;
    int n;
    b = '0;
    for (int i = 0; i < DATA_W; i++) b[1 + i] = d[i];
    n = 1 + DATA_W;
    if (has_parity(pm)) begin
      b[n] = (($countones(d) % 2) == 1) ^ (pm == 2'b10);
      n++;
    end
    b[n] = 1'b1;
    if (s2) b[n + 1] = 1'b1;
    return b;
  endfunction

  // TX monitor: samples every clk of a frame; uni records that each bit held for OSR clk.
  logic [15:0] got_q[$];
  bit          uni_q[$];
  initial begin : tx_mon
    int n;
    logic [15:0] b;
    bit uni, abrt;
    forever begin
      @(negedge clk);
      if (mon_en && reset === 1'b1 && tx === 1'b0) begin
        n = frame_len(parity_mode, stop2);
        b = '0;
        uni = 1'b1;
        abrt = 1'b0;
        for (int k = 0; k < n * OSR; k++) begin
          if (k > 0) @(negedge clk);
          if (reset !== 1'b1) begin
            abrt = 1'b1;
            break;
          end
          if (k % OSR == 0) b[k / OSR] = tx;
          else if (tx !== b[k / OSR]) uni = 1'b0;
        end
        if (!abrt) begin
          got_q.push_back(b);
          uni_q.push_back(uni);
        end
      end
    end
  end

  // RX monitor: every rx_valid high sample is one strobe.
  logic [DATA_W+1:0] rxq[$];
  int rx_strobes = 0;
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rx_strobes++;
      rxq.push_back({rx_frame_err, rx_parity_err, rx_data});
    end
  end

  task automatic push_word(input logic [DATA_W-1:0] d);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic expect_frame(input string tag, input logic [15:0] exp, output logic [15:0] g);
    bit u;
    g = '0;
    for (int t = 0; t < 4000 && got_q.size() == 0; t++) @(posedge clk);
    check({tag, "_present"}, 32'(got_q.size() > 0), 32'd1);
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      u = uni_q.pop_front();
      check({tag, "_bits"}, 32'(g), 32'(exp));
      check({tag, "_width"}, 32'(u), 32'd1);
    end
  endtask

  task automatic expect_rx(input string tag, input logic [DATA_W+1:0] exp, input int limit);
    for (int t = 0; t < limit && rxq.size() == 0; t++) @(negedge clk);
    check({tag, "_present"}, 32'(rxq.size() > 0), 32'd1);
    if (rxq.size() > 0) check({tag, "_word"}, 32'(rxq.pop_front()), 32'(exp));
  endtask

  task automatic drive_rx_frame(input logic [DATA_W-1:0] d, input logic [1:0] pm,
                                input bit flip, input bit stop_low);
    logic [15:0] b;
    int n;
    b = frame_bits(d, pm, 1'b0);
    n = frame_len(pm, 1'b0);
    if (flip && has_parity(pm)) b[n - 2] = ~b[n - 2];
    if (stop_low) b[n - 1] = 1'b0;
    for (int i = 0; i < n; i++) begin
      rx_drv = b[i];
      repeat (OSR) @(negedge clk);
    end
    if (!stop_low) rx_drv = 1'b1;
  endtask

  initial begin : stim
    logic [15:0] g;
    logic [DATA_W-1:0] words[FIFO_DEPTH + 2];
    logic [DATA_W-1:0] d;
    logic [1:0] pm;
    logic s2;
    bit flip;
    int base;

    // Reset values while reset is held
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_perr", 32'(rx_parity_err), 32'd0);
    check("rst_ferr", 32'(rx_frame_err), 32'd0);
    reset = 1'b1;

    repeat (200) @(negedge clk);
    check("idle_tx", 32'(tx), 32'd1);
    check("idle_tx_ready", 32'(tx_ready), 32'd1);
    check("idle_tx_busy", 32'(tx_busy), 32'd0);
    check("idle_no_rx_valid", 32'(rx_strobes), 32'd0);

    // 0xA5, no parity, one stop bit
    push_word(8'hA5);
    expect_frame("a5", frame_bits(8'hA5, 2'b00, 1'b0), g);
    check("a5_literal", 32'(g), 32'h34A);
    @(negedge clk);
    check("a5_busy_fall", 32'(tx_busy), 32'd0);
    check("a5_tx_idle", 32'(tx), 32'd1);

    parity_mode = 2'b01;
    push_word(8'h07);
    expect_frame("even07", frame_bits(8'h07, 2'b01, 1'b0), g);
    check("even07_pbit", 32'(g[9]), 32'd1);
    parity_mode = 2'b10;
    push_word(8'h07);
    expect_frame("odd07", frame_bits(8'h07, 2'b10, 1'b0), g);
    check("odd07_pbit", 32'(g[9]), 32'd0);
    parity_mode = 2'b00;
    stop2 = 1'b1;
    push_word(8'h07);
    expect_frame("stop2", frame_bits(8'h07, 2'b00, 1'b1), g);
    check("stop2_high", 32'(g[10:9]), 32'd3);
    stop2 = 1'b0;

    // FIFO overflow: FIFO_DEPTH+2 back-to-back writes
    for (int i = 0; i < FIFO_DEPTH + 2; i++) words[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < FIFO_DEPTH + 2; i++) begin
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = words[i];
    end
    @(negedge clk);
    tx_valid = 1'b0;
    check("full_tx_ready", 32'(tx_ready), 32'd0);
    check("full_tx_busy", 32'(tx_busy), 32'd1);
    for (int i = 0; i < FIFO_DEPTH + 1; i++)
      expect_frame($sformatf("fifo%0d", i), frame_bits(words[i], 2'b00, 1'b0), g);
    repeat (400) @(negedge clk);
    check("fifo_dropped", 32'(got_q.size()), 32'd0);
    check("fifo_drain_ready", 32'(tx_ready), 32'd1);
    check("fifo_drain_busy", 32'(tx_busy), 32'd0);

    // Loopback 0x3C even parity
    loop_en = 1'b1;
    parity_mode = 2'b01;
    base = rx_strobes;
    push_word(8'h3C);
    expect_frame("loop3c", frame_bits(8'h3C, 2'b01, 1'b0), g);
    expect_rx("loop3c_rx", {2'b00, 8'h3C}, 400);
    repeat (50) @(negedge clk);
    check("loop3c_one_strobe", 32'(rx_strobes - base), 32'd1);

    // Randomized loopback frames
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      pm = 2'($urandom_range(0, 3));
      s2 = 1'($urandom_range(0, 1));
      parity_mode = pm;
      stop2 = s2;
      push_word(d);
      expect_frame($sformatf("rloop%0d", i), frame_bits(d, pm, s2), g);
      expect_rx($sformatf("rloop%0d_rx", i), {2'b00, d}, 400);
    end
    stop2 = 1'b0;

    // Slower baud through loopback
    mon_en = 1'b0;
    parity_mode = 2'b00;
    baud_div = 16'd2;
    repeat (10) @(negedge clk);
    push_word(8'h96);
    expect_rx("div2_rx", {2'b00, 8'h96}, 1200);
    for (int t = 0; t < 2000 && tx_busy; t++) @(negedge clk);
    check("div2_done", 32'(tx_busy), 32'd0);
    baud_div = 16'd0;
    repeat (10) @(negedge clk);
    got_q.delete();
    uni_q.delete();
    mon_en = 1'b1;

    // Direct RX: flipped parity, then randomized frames
    loop_en = 1'b0;
    parity_mode = 2'b01;
    drive_rx_frame(8'h3C, 2'b01, 1'b1, 1'b0);
    expect_rx("perr3c", {2'b01, 8'h3C}, 100);
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      pm = 2'($urandom_range(0, 3));
      flip = 1'($urandom_range(0, 1));
      parity_mode = pm;
      repeat (4) @(negedge clk);
      drive_rx_frame(d, pm, flip, 1'b0);
      expect_rx($sformatf("rdir%0d", i), {1'b0, flip && has_parity(pm), d}, 100);
    end

    // Break: low stop bit, held low
    parity_mode = 2'b00;
    repeat (20) @(negedge clk);
    drive_rx_frame(8'h5A, 2'b00, 1'b0, 1'b1);
    expect_rx("ferr", {2'b10, 8'h5A}, 100);
    base = rx_strobes;
    repeat (400) @(negedge clk);
    check("ferr_no_rearm", 32'(rx_strobes - base), 32'd0);
    check("ferr_hold_data", 32'(rx_data), 32'h5A);
    check("ferr_hold_flag", 32'(rx_frame_err), 32'd1);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    drive_rx_frame(8'h81, 2'b00, 1'b0, 1'b0);
    expect_rx("rearm", {2'b00, 8'h81}, 100);

    // 4-tick glitch
    repeat (40) @(negedge clk);
    base = rx_strobes;
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch_reject", 32'(rx_strobes - base), 32'd0);

    // Reset in the middle of a TX frame with loopback active
    loop_en = 1'b1;
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    repeat (50) @(negedge clk);
    base = rx_strobes;
    reset = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_ready", 32'(tx_ready), 32'd1);
    check("mid_rst_busy", 32'(tx_busy), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (600) @(negedge clk);
    check("post_rst_no_frame", 32'(got_q.size()), 32'd0);
    check("post_rst_busy", 32'(tx_busy), 32'd0);
    check("post_rst_no_rx", 32'(rx_strobes - base), 32'd0);
    check("post_rst_rx_data", 32'(rx_data), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
